// File: rtl/mac_result_fifo.sv
// Result buffer behind the FP MAC pipeline with an in-flight credit stall.
// Optional counters: define MAC_RESULT_FIFO_STATS_EN.
module mac_result_fifo #(
  parameter int DataWidth       = 32,
  parameter int Depth           = 16,
  parameter int AddrWidth       = $clog2(Depth),
  parameter int Pipeline_Stages = 12
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 IssueNOP,
  input  logic                 NOPIn,
  input  logic [DataWidth-1:0] DataIn,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [DataWidth-1:0] DataOut,
  output logic [AddrWidth:0]   Count,
  output logic                 IssueStall,
`ifdef MAC_RESULT_FIFO_STATS_EN
  output logic [31:0]          AcceptCnt,
  output logic [15:0]          DropCnt,
`endif
  output logic                 Overflow
);

  localparam int IW = $clog2(Pipeline_Stages + 1) + 1;
  localparam int SW = AddrWidth + IW + 1;

  localparam logic [AddrWidth:0] DepthC = (AddrWidth + 1)'(Depth);
  localparam logic [IW-1:0]      IfMax  = '1;

  logic [DataWidth-1:0] mem [Depth];
  logic [AddrWidth-1:0] wr_ptr;
  logic [AddrWidth-1:0] rd_ptr;
  logic [IW-1:0]        InFlight;

  logic       rd_en;
  logic       wr_en;
  logic       drop;
  logic       issue;
  logic       res;
  logic [SW-1:0] occ;

  assign issue    = !IssueNOP;
  assign res      = !NOPIn;
  assign OutValid = (Count != '0);
  assign rd_en    = OutValid && OutReady;
  assign wr_en    = res && ((Count < DepthC) || rd_en);
  assign drop     = res && !wr_en;
  assign DataOut  = mem[rd_ptr];

  assign occ        = SW'(Count) + SW'(InFlight);
  assign IssueStall = (occ >= SW'(Depth));

  // storage array, deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= DataIn;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AddrWidth'(1);
      if (rd_en) rd_ptr <= rd_ptr + AddrWidth'(1);
      unique case (1'b1)
        wr_en && !rd_en: Count <= Count + (AddrWidth + 1)'(1);
        !wr_en && rd_en: Count <= Count - (AddrWidth + 1)'(1);
        default:         Count <= Count;
      endcase
    end
  end

  // operations issued into the MAC whose results are not back yet
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      InFlight <= '0;
    end else begin
      unique case (1'b1)
        issue && !res: begin
          if (InFlight != IfMax) InFlight <= InFlight + IW'(1);
        end
        !issue && res: begin
          if (InFlight != '0) InFlight <= InFlight - IW'(1);
        end
        default: InFlight <= InFlight;
      endcase
    end
  end

  // sticky drop flag
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) Overflow <= 1'b0;
    else if (drop) Overflow <= 1'b1;
  end

`ifdef MAC_RESULT_FIFO_STATS_EN
  // accept counter wraps, drop counter saturates
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      AcceptCnt <= '0;
      DropCnt   <= '0;
    end else begin
      if (wr_en) AcceptCnt <= AcceptCnt + 32'd1;
      if (drop && DropCnt != 16'hFFFF) DropCnt <= DropCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_result_fifo.sv
// Bench for mac_result_fifo: vector table, corner sequences and a
// queue-based reference model under random traffic.
module tb_mac_result_fifo;

  localparam int DW = 32;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk;
  logic          aclr;
  logic          IssueNOP;
  logic          NOPIn;
  logic [DW-1:0] DataIn;
  logic          OutValid;
  logic          OutReady;
  logic [DW-1:0] DataOut;
  logic [AW:0]   Count;
  logic          IssueStall;
  logic          Overflow;
`ifdef MAC_RESULT_FIFO_STATS_EN
  logic [31:0]   AcceptCnt;
  logic [15:0]   DropCnt;
`endif

  mac_result_fifo #(
    .DataWidth(DW), .Depth(DP), .Pipeline_Stages(12)
  ) dut (
    .clk(clk), .aclr(aclr),
    .IssueNOP(IssueNOP), .NOPIn(NOPIn), .DataIn(DataIn),
    .OutValid(OutValid), .OutReady(OutReady), .DataOut(DataOut),
    .Count(Count), .IssueStall(IssueStall),
`ifdef MAC_RESULT_FIFO_STATS_EN
    .AcceptCnt(AcceptCnt), .DropCnt(DropCnt),
`endif
    .Overflow(Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] q[$];
  logic [31:0] outs[$];
  int  m_inflight;
  bit  m_ovf;
  int  m_acc;
  int  m_drop;
  int  maxc;

  typedef struct {
    bit          iss_n;
    bit          nop;
    logic [31:0] din;
    bit          rdy;
    int          cnt;
    bit          vld;
    logic [31:0] dat;
    bit          stall;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_inflight = 0;
    m_ovf = 0;
    m_acc = 0;
    m_drop = 0;
  endtask

  // one clock: drive, advance model, compare after the edge
  task automatic cyc(input bit iss_n, input bit nop,
                     input logic [31:0] din, input bit rdy);
    bit rd;
    bit wr;
    int nf;
    IssueNOP = iss_n;
    NOPIn    = nop;
    DataIn   = din;
    OutReady = rdy;
    rd = (q.size() != 0) && rdy;
    wr = !nop && ((q.size() < DP) || rd);
    #1;
    if (OutValid && rdy) outs.push_back(DataOut);
    if (rd) void'(q.pop_front());
    if (wr) begin
      q.push_back(din);
      m_acc++;
    end else if (!nop) begin
      m_ovf = 1;
      m_drop++;
    end
    nf = m_inflight + (iss_n ? 0 : 1) - (nop ? 0 : 1);
    m_inflight = (nf < 0) ? 0 : nf;
    @(posedge clk);
    #1;
    if (int'(Count) > maxc) maxc = int'(Count);
    chk("count", 32'(Count), 32'(q.size()));
    chk("valid", 32'(OutValid), 32'(q.size() != 0));
    chk("stall", 32'(IssueStall), 32'((q.size() + m_inflight) >= DP));
    chk("overflow", 32'(Overflow), 32'(m_ovf));
    if (q.size() != 0) chk("data", DataOut, q[0]);
  endtask

  task automatic do_reset();
    #2;
    aclr = 1'b0;
    #1;
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_valid", 32'(OutValid), 32'd0);
    chk("rst_stall", 32'(IssueStall), 32'd0);
    chk("rst_ovf", 32'(Overflow), 32'd0);
`ifdef MAC_RESULT_FIFO_STATS_EN
    chk("rst_acc", AcceptCnt, 32'd0);
    chk("rst_drop", 32'(DropCnt), 32'd0);
`endif
    IssueNOP = 1'b1;
    NOPIn    = 1'b1;
    OutReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    aclr = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    int pushed;
    int guard;
    int issued;
    bit [11:0] pipe;
    bit want;
    bit ib;
    logic [31:0] head;

    tbl[0] = '{1'b1, 1'b0, 32'h4270_0000, 1'b1, 1, 1'b1, 32'h4270_0000, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h4796_4A00, 1'b1, 1, 1'b1, 32'h4796_4A00, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h0,         1'b1, 0, 1'b0, 32'h0,         1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'h0,         1'b0, 0, 1'b0, 32'h0,         1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h1234_5678, 1'b0, 1, 1'b1, 32'h1234_5678, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 32'h0,         1'b1, 0, 1'b0, 32'h0,         1'b0};

    aclr = 1'b0;
    IssueNOP = 1'b1;
    NOPIn = 1'b1;
    DataIn = '0;
    OutReady = 1'b0;
    maxc = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // wrap-around: 1..40 through a 16-deep buffer, random drain
    outs.delete();
    pushed = 0;
    guard = 0;
    maxc = 0;
    while (pushed < 40 && guard < 1000) begin
      ib = 1'($urandom_range(0, 1));
      if (q.size() < DP) begin
        cyc(1'b1, 1'b0, 32'(pushed + 1), ib);
        pushed++;
      end else begin
        cyc(1'b1, 1'b1, 32'h0, ib);
      end
      guard++;
    end
    chk("wrap_pushed", 32'(pushed), 32'd40);
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      cyc(1'b1, 1'b1, 32'h0, 1'b1);
      guard++;
    end
    chk("wrap_drained", 32'(q.size()), 32'd0);
    chk("wrap_outs", 32'(outs.size()), 32'd40);
    for (int i = 0; i < 40 && i < outs.size(); i++)
      chk("wrap_order", outs[i], 32'(i + 1));
    chk("wrap_maxcount", 32'(maxc > DP), 32'd0);

    // full boundary
    for (int i = 0; i < DP; i++)
      cyc(1'b1, 1'b0, 32'hA000_0000 + 32'(i), 1'b0);
    chk("full_count", 32'(Count), 32'd16);
    chk("full_head", DataOut, 32'hA000_0000);
    cyc(1'b1, 1'b0, 32'hB000_0001, 1'b1);
    chk("full_rw_count", 32'(Count), 32'd16);
    chk("full_rw_ovf", 32'(Overflow), 32'd0);
    chk("full_rw_head", DataOut, 32'hA000_0001);
    head = DataOut;
    cyc(1'b1, 1'b0, 32'hB000_0002, 1'b0);
    chk("drop_ovf", 32'(Overflow), 32'd1);
    chk("drop_head", DataOut, 32'hA000_0001);
    chk("drop_count", 32'(Count), 32'd16);
    cyc(1'b1, 1'b0, 32'hB000_0003, 1'b1);

    // reset while buffer is full and results are arriving
    NOPIn = 1'b0;
    do_reset();

    // ordering and basic behaviour from the vector table
    outs.delete();
    foreach (tbl[i]) begin
      cyc(tbl[i].iss_n, tbl[i].nop, tbl[i].din, tbl[i].rdy);
      chk("tbl_count", 32'(Count), 32'(tbl[i].cnt));
      chk("tbl_valid", 32'(OutValid), 32'(tbl[i].vld));
      chk("tbl_stall", 32'(IssueStall), 32'(tbl[i].stall));
      if (tbl[i].vld) chk("tbl_data", DataOut, tbl[i].dat);
    end
    chk("order_n", 32'(outs.size()), 32'd3);
    if (outs.size() >= 2) begin
      chk("order_first", outs[0], 32'h4270_0000);
      chk("order_second", outs[1], 32'h4796_4A00);
    end

    // credit: 4 buffered, feeder issues into a 12-stage MAC under stall
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b0, 32'hC000_0000 + 32'(i), 1'b0);
    pipe = '0;
    issued = 0;
    for (int t = 0; t < 90; t++) begin
      want = (t < 40);
      ib = !(want && !IssueStall);
      cyc(ib, !pipe[11], 32'hC100_0000 + 32'(t), t >= 30);
      pipe = {pipe[10:0], !ib};
      if (!ib) begin
        issued++;
        if (issued == 12) chk("credit_stall_12", 32'(IssueStall), 32'd1);
      end
    end
    chk("credit_ovf", 32'(Overflow), 32'd0);
    chk("credit_inflight", 32'(dut.InFlight), 32'd0);
    chk("credit_empty", 32'(Count), 32'd0);

    // random traffic against the model
    for (int t = 0; t < 400; t++) begin
      cyc(($urandom % 10) >= 4, 1'($urandom % 2), $urandom,
          ($urandom % 4) < (((t / 100) % 2) != 0 ? 1 : 3));
    end
`ifdef MAC_RESULT_FIFO_STATS_EN
    chk("stats_acc", AcceptCnt, 32'(m_acc));
    chk("stats_drop", 32'(DropCnt), 32'(m_drop));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
